// File: rtl/alu_pkg.sv
// Shared types and constants for the LEGv8 multi-cycle ALU control unit.
// Optional SDIV support is enabled by defining ALU_DIV_EN.
package alu_pkg;

    typedef enum logic [3:0] {
        CTL_AND     = 4'b0000,
        CTL_ORR     = 4'b0001,
        CTL_ADD     = 4'b0010,
        CTL_EOR     = 4'b0011,
        CTL_SUB     = 4'b0110,
        CTL_PASSB   = 4'b0111,
        CTL_LSL     = 4'b1000,
        CTL_LSR     = 4'b1001,
        CTL_MUL     = 4'b1010,
        CTL_SDIV    = 4'b1011,
        CTL_ILLEGAL = 4'b1111
    } alu_ctl_e;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;
    localparam logic [10:0] OP_MUL  = 11'b10011011000;
    localparam logic [10:0] OP_SDIV = 11'b10011010110;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_CBZ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } mc_state_e;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational decode of (ALUOp, opcode) into the ALU select and op class.
// SDIV decodes only when ALU_DIV_EN is defined; otherwise it is illegal.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [1:0]  ALUOp,
    input  logic [10:0] opcode,
    output logic [3:0]  ALUCtl,
    output logic        is_mc,
    output logic        is_illegal
);

    alu_ctl_e ctl;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        ctl   = CTL_ILLEGAL;
        is_mc = 1'b0;
        case (ALUOp)
            ALUOP_MEM: ctl = CTL_ADD;
            ALUOP_CBZ: ctl = CTL_PASSB;
            ALUOP_RTYPE: begin
                case (opcode)
                    OP_ADD: ctl = CTL_ADD;
                    OP_SUB: ctl = CTL_SUB;
                    OP_AND: ctl = CTL_AND;
                    OP_ORR: ctl = CTL_ORR;
                    OP_EOR: ctl = CTL_EOR;
                    OP_LSL: ctl = CTL_LSL;
                    OP_LSR: ctl = CTL_LSR;
                    OP_MUL: begin
                        ctl   = CTL_MUL;
                        is_mc = 1'b1;
                    end
`ifdef ALU_DIV_EN
                    OP_SDIV: begin
                        ctl   = CTL_SDIV;
                        is_mc = 1'b1;
                    end
`endif
                    default: ctl = CTL_ILLEGAL;
                endcase
            end
            default: ctl = CTL_ILLEGAL;
        endcase
    end

    assign ALUCtl     = ctl;
    assign is_illegal = (ctl == CTL_ILLEGAL);

endmodule

// File: rtl/alu_ctrl_mc.sv
// Multi-cycle ALU control: decode plus an IDLE/RUN/DONE sequencer for MUL/SDIV.
// Define ALU_DIV_EN to accept SDIV; without it SDIV is reported illegal.
module alu_ctrl_mc
    import alu_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int MUL_BPC = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid,
    input  logic                      flush,
    input  logic [10:0]               opcode,
    input  logic [1:0]                ALUOp,
    output logic [3:0]                ALUCtl,
    output logic                      stall,
    output logic                      mc_start,
    output logic                      mc_step,
    output logic                      mc_done,
    output logic [$clog2(DATA_W)-1:0] iter,
    output logic                      illegal
);

    localparam int ITER_W = $clog2(DATA_W);
    localparam int N_MUL  = DATA_W / MUL_BPC;
`ifdef ALU_DIV_EN
    localparam int N_DIV  = DATA_W;
`endif

    logic [3:0]        dec_ctl;
    logic              dec_mc;
    logic              dec_illegal;
    mc_state_e         state;
    logic [3:0]        ctl_q;
    logic [ITER_W-1:0] iter_q;
    logic [ITER_W-1:0] start_iter;
    logic              accept;

    alu_ctrl_dec u_dec (
        .ALUOp      (ALUOp),
        .opcode     (opcode),
        .ALUCtl     (dec_ctl),
        .is_mc      (dec_mc),
        .is_illegal (dec_illegal)
    );

    always_comb begin
        start_iter = ITER_W'(N_MUL - 1);
`ifdef ALU_DIV_EN
        if (dec_ctl == CTL_SDIV)
            start_iter = ITER_W'(N_DIV - 1);
`endif
    end

    assign accept = valid && dec_mc && !flush && (state == ST_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            iter_q <= '0;
            ctl_q  <= 4'b0000;
        end else if (flush) begin
            state  <= ST_IDLE;
            iter_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state  <= ST_RUN;
                        iter_q <= start_iter;
                        ctl_q  <= dec_ctl;
                    end
                end
                // Exit at zero so the down-counter never wraps.
                ST_RUN: begin
                    if (iter_q == '0)
                        state <= ST_DONE;
                    else
                        iter_q <= iter_q - ITER_W'(1);
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Handshake outputs are forced low while reset is held; ALUCtl keeps decoding.
    always_comb begin
        ALUCtl   = dec_ctl;
        stall    = 1'b0;
        mc_start = 1'b0;
        mc_step  = 1'b0;
        mc_done  = 1'b0;
        illegal  = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    stall    = accept;
                    mc_start = accept;
                    illegal  = valid && dec_illegal;
                end
                ST_RUN: begin
                    ALUCtl  = ctl_q;
                    stall   = 1'b1;
                    mc_step = 1'b1;
                end
                ST_DONE: begin
                    ALUCtl  = ctl_q;
                    mc_done = 1'b1;
                end
                default: ALUCtl = dec_ctl;
            endcase
        end
    end

    assign iter = iter_q;

endmodule

// File: doc/alu_ctrl_mc.md
# alu_ctrl_mc

Multi-cycle ALU control unit for the LEGv8 core; a parametrised successor to the single-cycle ALU control decoder. It decodes `ALUOp`/`opcode` into the 4-bit `ALUCtl` for single-cycle operations and adds the extended ops EOR, LSL, LSR, MUL and SDIV. For MUL and SDIV it sequences an iterative datapath, stalling the pipeline until the result is ready. It sits between the main control unit and the EX-stage ALU / iterative mul-div datapath.

## Interface
- `DATA_W`, 64: operand width; a power of 2, at least 8.
- `MUL_BPC`, 1: multiplier bits retired per cycle; must divide `DATA_W`. MUL iterations `N_MUL = DATA_W/MUL_BPC`.
- `N_DIV`, fixed at `DATA_W`: SDIV iterations, radix-2. This is a localparam.
- `clk` in 1: the single clock. Reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `valid` in 1: an EX-stage instruction is present.
- `flush` in 1: pipeline flush; aborts any in-flight op.
- `opcode` in 11: instruction bits [31:21].
- `ALUOp` in 2: from the control unit.
- `ALUCtl` out 4: ALU operation select.
- `stall` out 1: hold IF/ID/EX.
- `mc_start` out 1: 1-cycle pulse that loads the iterative datapath.
- `mc_step` out 1: advance the iterative datapath one iteration.
- `mc_done` out 1: 1-cycle pulse; the datapath result is valid this cycle.
- `iter` out `$clog2(DATA_W)`: remaining iterations minus 1.
- `illegal` out 1: undecodable op presented with `valid`.

## Operation
- **Decode for `ALUOp`=00:** `ALUCtl` = 0010 (add, for LDUR/STUR).
- **Decode for `ALUOp`=01:** `ALUCtl` = 0111 (pass B, for CBZ).
- **Decode for `ALUOp`=10 (R-type), single-cycle ops:**
  - ADD 10001011000 → 0010
  - SUB 11001011000 → 0110
  - AND 10001010000 → 0000
  - ORR 10101010000 → 0001
  - EOR 11001010000 → 0011
  - LSL 11010011011 → 1000
  - LSR 11010011010 → 1001
- **Decode for `ALUOp`=10 (R-type), multi-cycle ops:**
  - MUL 10011011000 → 1010
  - SDIV 10011010110 → 1011
- **Illegal decode:** any other R-type opcode, or `ALUOp`=11, gives `ALUCtl` = 1111.
  - `illegal` = `valid` & (state==IDLE).
  - No stall is raised.
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - `ALUCtl` is combinational from the inputs.
  - If `valid` & multi-cycle op: `stall`=1 and `mc_start`=1. Next state RUN, `iter` ← N−1, and the decoded `ALUCtl` is latched into a register.
- **RUN:**
  - `ALUCtl` = latched value; `stall`=1; `mc_step`=1.
  - `iter` decrements each cycle.
  - When `iter`==0, next state is DONE.
  - `valid`/`opcode` changes are ignored.
- **DONE:**
  - `ALUCtl` = latched value; `stall`=0; `mc_done`=1.
  - Next state IDLE; the pipeline advances on this edge.
- **flush:** in any state, next state IDLE and `iter` ← 0. `flush` has priority over all other transitions. In IDLE, `flush` suppresses `mc_start`.
- **Back-to-back ops:** a multi-cycle op presented in the cycle after DONE (now in IDLE) starts normally. There are no bubbles beyond DONE.

## Timing
- **Reset values:** state=IDLE, `iter`=0, latched `ALUCtl`=0000.
- **Outputs during reset:** `stall`, `mc_start`, `mc_step`, `mc_done` and `illegal` are all 0. `ALUCtl` follows the combinational decode.
- **Single-cycle ops:** zero latency; `ALUCtl` is valid in the same cycle.
- **MUL schedule, accept at cycle 0:**
  - cycle 0: `mc_start`, `stall`.
  - cycles 1..N_MUL: RUN.
  - cycle N_MUL+1: `mc_done`.
  - Total stall cycles = N_MUL+1.
- **SDIV schedule:** the same with N_DIV, i.e. N_DIV+1 stall cycles.
- **`iter` width:** sized for the largest N. Decrement never wraps, because the RUN→DONE exit happens at 0.
- **Reset mid-RUN:** the state returns to IDLE at the next edge, and `stall` deasserts that cycle.
- **Outputs are one-hot-exclusive:** `mc_start`, `mc_step` and `mc_done` are never simultaneously 1.

## Configuration
- `ALU_DIV_EN` defined: SDIV decodes as above.
- `ALU_DIV_EN` undefined: SDIV opcode decodes as illegal (`ALUCtl`=1111, `illegal`=1, no stall). `N_DIV` is not used for `iter` sizing.

## Structure
- **Package `alu_pkg`:**
  - `alu_ctl_e` enum of the 4-bit codes above.
  - localparam opcode constants for all 9 ops.
  - ALUOp encodings.
  - FSM state typedef.
- **Sub-module `alu_ctrl_dec`:** purely combinational decode of (`ALUOp`, `opcode`) → (`ALUCtl`, `is_mc`, `is_illegal`). The top-level holds the FSM, latch and counter.
- **Bench:** uses `common.vh` for `CYCLE` and `TB_BEGIN`/`TB_END`.

## Test plan
- **Single-cycle decode:** ALUOp 00/01 with opcode=x → 0010/0111. R-type ADD/SUB/AND/ORR/EOR/LSL/LSR → 0010/0110/0000/0001/0011/1000/1001. `stall`=0 throughout.
- **MUL, `DATA_W`=64, `MUL_BPC`=1:**
  - `valid`+MUL → `mc_start` at cycle 0.
  - 64 `mc_step` cycles with `iter` 63→0.
  - `mc_done` at cycle 65; `stall` high cycles 0..64; `ALUCtl`=1010 throughout.
  - With `MUL_BPC`=4: 16 steps.
- **SDIV with `ALU_DIV_EN`:** 64 steps, `ALUCtl`=1011. Without the macro: `illegal`=1, `ALUCtl`=1111, no stall.
- **Flush and reset aborts:**
  - `flush` at RUN step 10 → IDLE next cycle; `stall`=0; no `mc_done`.
  - `rst` mid-RUN → same response.
- **Illegal ops:** opcode 11111111111 with ALUOp 10, or ALUOp 11 → `ALUCtl`=1111 and `illegal`=1. With `valid`=0, `illegal`=0.
- **Back-to-back:** MUL followed immediately by ADD → ADD decodes 0010 in the cycle after `mc_done`. Opcode changes during RUN do not alter the latched `ALUCtl`.
